// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate-format definitions.
// Contents: imm_src_e format encoding, instruction/selector widths, and a
// helper that reports whether a format encoding is legal.
package riscv_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned IMM_SRC_W = 3;
  localparam int unsigned XLEN_32   = 32;
  localparam int unsigned XLEN_64   = 64;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_RS6 = 3'b110,
    IMM_RS7 = 3'b111
  } imm_src_e;

  // Z is only a real format when the CSR zero-extended immediate is enabled.
  function automatic logic imm_src_legal(input imm_src_e src, input logic zimm_en);
    case (src)
      IMM_I, IMM_S, IMM_B, IMM_J, IMM_U: imm_src_legal = 1'b1;
      IMM_Z:                             imm_src_legal = zimm_en;
      default:                           imm_src_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder and branch/jump target adder.
// Ports: instr (raw instruction), imm_src (format), pc (instruction address)
//        -> imm_c (extended immediate), target_c (pc + imm_c), illegal_c.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          ZIMM_EN = 1'b1
) (
  input  logic [INSTR_W-1:0]   instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  input  logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      imm_c,
  output logic [XLEN-1:0]      target_c,
  output logic                 illegal_c
);

  imm_src_e src_c;
  logic     unused_c;

  // Opcode bits carry no immediate data.
  assign unused_c = ^instr[6:0];
  assign src_c    = imm_src_e'(imm_src);

  // Signed casts sign-extend from instr[31]; Z is zero-extended.
  always_comb begin
    imm_c     = '0;
    illegal_c = ~imm_src_legal(src_c, ZIMM_EN);
    if (!illegal_c) begin
      case (src_c)
        IMM_I:   imm_c = XLEN'($signed(instr[31:20]));
        IMM_S:   imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
        IMM_B:   imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                        instr[11:8], 1'b0}));
        IMM_J:   imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                        instr[30:21], 1'b0}));
        IMM_U:   imm_c = XLEN'($signed({instr[31:12], 12'b0}));
        IMM_Z:   imm_c = XLEN'(instr[19:15]);
        default: imm_c = '0;
      endcase
    end
  end

  // Illegal entries carry imm 0, so the target degenerates to pc.
  assign target_c = pc + imm_c;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode at the input, then a 2-entry
// skid buffer (main + skid register) with fully registered outputs.
// Ports: clk, rst_n; in_valid/in_ready/in_instr/in_imm_src/in_pc (upstream);
//        flush; out_valid/out_ready/out_imm/out_target/out_illegal (downstream).
module imm_gen_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          ZIMM_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_target,
  output logic                 out_illegal
);

  localparam int unsigned PW = 2 * XLEN + 1;

  logic [XLEN-1:0] dec_imm_c;
  logic [XLEN-1:0] dec_target_c;
  logic            dec_illegal_c;
  logic [PW-1:0]   in_payload_c;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;

  logic main_valid_q, skid_valid_q, ready_q;
  logic main_valid_d, skid_valid_d;
  logic accept_c, drain_c, main_free_c;
  logic load_main_in_c, load_main_skid_c, load_skid_c;

  imm_decode #(
    .XLEN    (XLEN),
    .ZIMM_EN (ZIMM_EN)
  ) u_decode (
    .instr     (in_instr),
    .imm_src   (in_imm_src),
    .pc        (in_pc),
    .imm_c     (dec_imm_c),
    .target_c  (dec_target_c),
    .illegal_c (dec_illegal_c)
  );

  assign in_payload_c = {dec_illegal_c, dec_target_c, dec_imm_c};

  // Occupancy next-state; the skid entry always has priority for the main slot.
  always_comb begin
    accept_c         = in_valid & ready_q;
    drain_c          = main_valid_q & out_ready;
    main_free_c      = ~main_valid_q | drain_c;
    load_main_skid_c = main_free_c & skid_valid_q;
    load_main_in_c   = main_free_c & ~skid_valid_q & accept_c;
    load_skid_c      = ~main_free_c & accept_c;
    main_valid_d     = main_valid_q;
    skid_valid_d     = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (main_free_c)      main_valid_d = skid_valid_q | accept_c;
      if (load_main_skid_c) skid_valid_d = 1'b0;
      if (load_skid_c)      skid_valid_d = 1'b1;
    end
  end

  // Valid bits and the registered ready (ready == skid register empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  // Payload registers; contents are ignored while the matching valid is low.
  always_ff @(posedge clk) begin
    if (load_main_skid_c) begin
      main_q <= skid_q;
    end else if (load_main_in_c) begin
      main_q <= in_payload_c;
    end
    if (load_skid_c) begin
      skid_q <= in_payload_c;
    end
  end

  assign in_ready                             = ready_q;
  assign out_valid                            = main_valid_q;
  assign {out_illegal, out_target, out_imm}   = main_q;

endmodule
